alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter ALU_LAT, default 1, cycles from operand drive to valid alu_result (legal 1..4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req_valid_0/req_valid_1  input  1  requester N has an operation.
REQ-006 SHALL have ports req_ready_0/req_ready_1  output  1  requester N operation accepted this cycle.
REQ-007 SHALL have ports req_ctrl_0/req_ctrl_1  input  4  ALU control code (ADD=0 .. SLTU=9).
REQ-008 SHALL have ports req_a_0/req_a_1, req_b_0/req_b_1  input  XLEN  operands.
REQ-009 SHALL have ports rsp_valid_0/rsp_valid_1  output  1  result for requester N available.
REQ-010 SHALL have ports rsp_ready_0/rsp_ready_1  input  1  requester N consumes result.
REQ-011 SHALL have port rsp_result  output  XLEN  registered result, shared by both responders.
REQ-012 SHALL have ports alu_ctrl  output  4,  alu_a/alu_b  output  XLEN  shared ALU drive.
REQ-013 SHALL have port alu_result  input  XLEN  shared ALU output.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE; one operation in flight.
REQ-015 IDLE: SHALL assert req_ready_N combinationally only for the arbitration winner among asserted req_valid; handshake = valid&&ready.
REQ-016 Arbitration SHALL be round-robin: with both valid, winner is requester not granted last; single valid wins unconditionally.
REQ-017 On handshake SHALL latch ctrl, a, b, owner id; go to EXEC; clear latency counter.
REQ-018 req_ctrl values 10..15 SHALL be latched as ADD (0).
REQ-019 EXEC: alu_ctrl/alu_a/alu_b SHALL be driven from latches; counter increments each cycle; after ALU_LAT EXEC cycles alu_result captured into rsp_result, go to RESP.
REQ-020 Outside EXEC alu_ctrl SHALL be 0 and alu_a/alu_b 0.
REQ-021 RESP: rsp_valid_owner SHALL be 1, other rsp_valid 0; rsp_result stable until rsp_ready_owner sampled 1; then IDLE.
REQ-022 rsp_ready of non-owner SHALL be ignored.
REQ-023 No acceptance in EXEC or RESP (req_ready_* = 0); minimum issue-to-issue spacing ALU_LAT+2 cycles.
REQ-024 Last-grant pointer SHALL update at handshake.
REQ-025 req_valid deassert before handshake SHALL be legal and leave no state.

Reset
REQ-026 On rst_n low SHALL go IDLE asynchronously; rsp_valid_*=0, rsp_result=0, latches=0, counter=0, last-grant = requester 1 (so requester 0 wins first tie).
REQ-027 Reset during EXEC/RESP SHALL abandon the operation; no response issued after release.
REQ-028 First handshake possible in first cycle with rst_n high.

Structure
REQ-029 Shared package alu_pkg SHALL hold the 4-bit ALU codes ADD..SLTU, FSM state encoding, NUM_REQ=2.
REQ-030 Round-robin grant SHALL be a sub-module rr_arbiter_2 (req[1:0], last, gnt[1:0]), combinational.

Verification
REQ-031 Req0 only, ctrl=ADD, a=5, b=7, ALU_LAT=1 -> req_ready_0 cycle 0, alu_a=5 cycle 1, rsp_valid_0 cycle 2, rsp_result=12.
REQ-032 Both valid after reset, ctrl0=SUB, ctrl1=XOR -> req0 served first, then req1; next tie goes to req0 again.
REQ-033 RESP with rsp_ready_0 low 3 cycles -> rsp_valid_0 and rsp_result held 3 cycles; req_ready_1 stays 0.
REQ-034 req_ctrl_1=4'd12, a=1, b=2 -> alu_ctrl=0 during EXEC, result 3.
REQ-035 rst_n pulsed low in EXEC (ALU_LAT=3) -> outputs reset immediately; no rsp_valid after release.
REQ-036 ALU_LAT=4 -> exactly 4 EXEC cycles, issue spacing 6 cycles under continuous requests.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : ALU operation codes, arbiter FSM states and requester count
//                shared by the two-requester ALU arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Undefined control codes execute as ADD.
    function automatic logic [3:0] sanitize_ctrl(input logic [3:0] ctrl);
        return (ctrl > ALU_SLTU) ? ALU_ADD : ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_2
//  Description : Combinational two-way round-robin grant; on a tie the
//                requester that was not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Shares one external ALU between two requesters with
//                round-robin arbitration; one operation in flight at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_0,
    input  logic            req_valid_1,
    output logic            req_ready_0,
    output logic            req_ready_1,
    input  logic [3:0]      req_ctrl_0,
    input  logic [3:0]      req_ctrl_1,
    input  logic [XLEN-1:0] req_a_0,
    input  logic [XLEN-1:0] req_a_1,
    input  logic [XLEN-1:0] req_b_0,
    input  logic [XLEN-1:0] req_b_1,
    output logic            rsp_valid_0,
    output logic            rsp_valid_1,
    input  logic            rsp_ready_0,
    input  logic            rsp_ready_1,
    output logic [XLEN-1:0] rsp_result,
    output logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    input  logic [XLEN-1:0] alu_result
);

    localparam logic [2:0] c_last_cnt = 3'(ALU_LAT - 1);

    arb_state_e        r_state;
    logic [3:0]        r_ctrl;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_owner;
    logic              r_last;
    logic [2:0]        r_cnt;
    logic              r_rsp_valid_0;
    logic              r_rsp_valid_1;
    logic [XLEN-1:0]   r_rsp_result;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_idle;
    logic               w_exec;
    logic               w_hs;
    logic               w_owner_ready;
    logic [3:0]         w_sel_ctrl;
    logic [XLEN-1:0]    w_sel_a;
    logic [XLEN-1:0]    w_sel_b;

    assign w_req = {req_valid_1, req_valid_0};

    rr_arbiter_2 u_rr_arbiter_2 (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_exec      = (r_state == ST_EXEC);
    assign req_ready_0 = w_idle & w_gnt[0];
    assign req_ready_1 = w_idle & w_gnt[1];
    assign w_hs        = w_idle & (|w_gnt);

    assign w_sel_ctrl    = w_gnt[1] ? req_ctrl_1 : req_ctrl_0;
    assign w_sel_a       = w_gnt[1] ? req_a_1    : req_a_0;
    assign w_sel_b       = w_gnt[1] ? req_b_1    : req_b_0;
    assign w_owner_ready = r_owner  ? rsp_ready_1 : rsp_ready_0;

    // The ALU sees the latched operation only while it is executing.
    assign alu_ctrl = w_exec ? r_ctrl : 4'd0;
    assign alu_a    = w_exec ? r_a    : '0;
    assign alu_b    = w_exec ? r_b    : '0;

    assign rsp_valid_0 = r_rsp_valid_0;
    assign rsp_valid_1 = r_rsp_valid_1;
    assign rsp_result  = r_rsp_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ctrl        <= 4'd0;
            r_a           <= '0;
            r_b           <= '0;
            r_owner       <= 1'b0;
            r_last        <= 1'b1;
            r_cnt         <= 3'd0;
            r_rsp_valid_0 <= 1'b0;
            r_rsp_valid_1 <= 1'b0;
            r_rsp_result  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hs) begin
                        r_ctrl  <= sanitize_ctrl(w_sel_ctrl);
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_owner <= w_gnt[1];
                        r_last  <= w_gnt[1];
                        r_cnt   <= 3'd0;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_last_cnt) begin
                        r_rsp_result  <= alu_result;
                        r_rsp_valid_0 <= ~r_owner;
                        r_rsp_valid_1 <= r_owner;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_owner_ready) begin
                        r_rsp_valid_0 <= 1'b0;
                        r_rsp_valid_1 <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench; three arbiters with ALU_LAT
//                1, 3 and 4, each driving its own behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;

    logic [NI-1:0] rv0, rv1, rr0, rr1, sv0, sv1, sr0, sr1;
    logic [3:0]    rc0 [NI];
    logic [3:0]    rc1 [NI];
    logic [3:0]    actl [NI];
    logic [31:0]   a0 [NI];
    logic [31:0]   b0 [NI];
    logic [31:0]   a1 [NI];
    logic [31:0]   b1 [NI];
    logic [31:0]   aa [NI];
    logic [31:0]   ab [NI];
    logic [31:0]   ares [NI];
    logic [31:0]   res [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] x,
                                              input logic [31:0] y);
        case (c)
            ALU_ADD:  return x + y;
            ALU_SUB:  return x - y;
            ALU_AND:  return x & y;
            ALU_OR:   return x | y;
            ALU_XOR:  return x ^ y;
            ALU_SLL:  return x << y[4:0];
            ALU_SRL:  return x >> y[4:0];
            ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
            ALU_SLT:  return {31'd0, $signed(x) < $signed(y)};
            ALU_SLTU: return {31'd0, x < y};
            default:  return 32'd0;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        alu_arbiter #(.XLEN(32), .ALU_LAT(L)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .req_valid_0 (rv0[g]),
            .req_valid_1 (rv1[g]),
            .req_ready_0 (rr0[g]),
            .req_ready_1 (rr1[g]),
            .req_ctrl_0  (rc0[g]),
            .req_ctrl_1  (rc1[g]),
            .req_a_0     (a0[g]),
            .req_a_1     (a1[g]),
            .req_b_0     (b0[g]),
            .req_b_1     (b1[g]),
            .rsp_valid_0 (sv0[g]),
            .rsp_valid_1 (sv1[g]),
            .rsp_ready_0 (sr0[g]),
            .rsp_ready_1 (sr1[g]),
            .rsp_result  (res[g]),
            .alu_ctrl    (actl[g]),
            .alu_a       (aa[g]),
            .alu_b       (ab[g]),
            .alu_result  (ares[g])
        );
        assign ares[g] = alu_model(actl[g], aa[g], ab[g]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int hs_c [3];
    int hs_n;
    int exec_n;

    initial begin
        rst_n = 1'b0;
        rv0 = '0; rv1 = '0; sr0 = '1; sr1 = '1;
        for (int i = 0; i < NI; i++) begin
            rc0[i] = 4'd0; rc1[i] = 4'd0;
            a0[i] = 32'd0; b0[i] = 32'd0; a1[i] = 32'd0; b1[i] = 32'd0;
        end
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid_0", {31'd0, sv0[0]}, 32'd0);
        check("rst_rsp_result",  res[0], 32'd0);
        check("rst_alu_a",       aa[0], 32'd0);
        check("rst_rsp_valid_1", {31'd0, sv1[1]}, 32'd0);

        // Single requester ADD 5+7, first cycle out of reset
        @(negedge clk);
        rst_n = 1'b1;
        rv0[0] = 1'b1; rc0[0] = ALU_ADD; a0[0] = 32'd5; b0[0] = 32'd7;
        #1;
        check("t1_ready0", {31'd0, rr0[0]}, 32'd1);
        check("t1_ready1", {31'd0, rr1[0]}, 32'd0);
        @(negedge clk);
        rv0[0] = 1'b0;
        #1;
        check("t1_exec_alu_a",    aa[0], 32'd5);
        check("t1_exec_alu_b",    ab[0], 32'd7);
        check("t1_exec_alu_ctrl", {28'd0, actl[0]}, 32'd0);
        check("t1_exec_ready0",   {31'd0, rr0[0]}, 32'd0);
        check("t1_exec_rspv0",    {31'd0, sv0[0]}, 32'd0);
        @(negedge clk);
        #1;
        check("t1_resp_valid0", {31'd0, sv0[0]}, 32'd1);
        check("t1_resp_valid1", {31'd0, sv1[0]}, 32'd0);
        check("t1_resp_result", res[0], 32'd12);
        @(negedge clk);
        #1;
        check("t1_idle_valid0", {31'd0, sv0[0]}, 32'd0);
        check("t1_idle_alu_a",  aa[0], 32'd0);

        // Round-robin tie after reset: SUB 20-6 for req0, XOR f0^ff for req1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        rv0[0] = 1'b1; rc0[0] = ALU_SUB; a0[0] = 32'd20;  b0[0] = 32'd6;
        rv1[0] = 1'b1; rc1[0] = ALU_XOR; a1[0] = 32'hF0; b1[0] = 32'hFF;
        #1;
        check("t2_tie1_ready0", {31'd0, rr0[0]}, 32'd1);
        check("t2_tie1_ready1", {31'd0, rr1[0]}, 32'd0);
        @(negedge clk);
        rc0[0] = ALU_ADD; a0[0] = 32'd1; b0[0] = 32'd1;
        #1;
        check("t2_exec_ctrl_sub", {28'd0, actl[0]}, 32'd1);
        check("t2_exec_ready1",   {31'd0, rr1[0]}, 32'd0);
        @(negedge clk);
        #1;
        check("t2_resp0_valid",  {31'd0, sv0[0]}, 32'd1);
        check("t2_resp0_result", res[0], 32'd14);
        @(negedge clk);
        #1;
        check("t2_tie2_ready1", {31'd0, rr1[0]}, 32'd1);
        check("t2_tie2_ready0", {31'd0, rr0[0]}, 32'd0);
        @(negedge clk);
        rv1[0] = 1'b0;
        #1;
        check("t2_exec_ctrl_xor", {28'd0, actl[0]}, 32'd4);
        @(negedge clk);
        #1;
        check("t2_resp1_valid1", {31'd0, sv1[0]}, 32'd1);
        check("t2_resp1_valid0", {31'd0, sv0[0]}, 32'd0);
        check("t2_resp1_result", res[0], 32'h0F);
        @(negedge clk);
        rv1[0] = 1'b1; rc1[0] = 4'd12; a1[0] = 32'd1; b1[0] = 32'd2;
        sr0[0] = 1'b0;
        #1;
        check("t2_tie3_ready0", {31'd0, rr0[0]}, 32'd1);
        check("t2_tie3_ready1", {31'd0, rr1[0]}, 32'd0);

        // Owner 0 stalls its response; requester 1 must wait
        @(negedge clk);
        rv0[0] = 1'b0;
        #1;
        check("t3_exec_ready1", {31'd0, rr1[0]}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("t3_hold_valid0",  {31'd0, sv0[0]}, 32'd1);
            check("t3_hold_result",  res[0], 32'd2);
            check("t3_hold_ready1",  {31'd0, rr1[0]}, 32'd0);
            check("t3_hold_valid1",  {31'd0, sv1[0]}, 32'd0);
        end
        @(negedge clk);
        sr0[0] = 1'b1;
        #1;
        check("t3_last_valid0", {31'd0, sv0[0]}, 32'd1);
        @(negedge clk);
        #1;
        check("t3_release_valid0", {31'd0, sv0[0]}, 32'd0);
        check("t3_release_ready1", {31'd0, rr1[0]}, 32'd1);

        // Undefined control 12 executes as ADD 1+2
        @(negedge clk);
        rv1[0] = 1'b0;
        #1;
        check("t4_exec_alu_ctrl", {28'd0, actl[0]}, 32'd0);
        check("t4_exec_alu_a",    aa[0], 32'd1);
        check("t4_exec_alu_b",    ab[0], 32'd2);
        @(negedge clk);
        #1;
        check("t4_resp_valid1", {31'd0, sv1[0]}, 32'd1);
        check("t4_resp_result", res[0], 32'd3);
        @(negedge clk);

        // ALU_LAT=3: reset asserted mid-EXEC abandons the operation
        rv0[1] = 1'b1; rc0[1] = ALU_ADD; a0[1] = 32'd2; b0[1] = 32'd2;
        #1;
        check("t5_ready0", {31'd0, rr0[1]}, 32'd1);
        @(negedge clk);
        rv0[1] = 1'b0;
        #1;
        check("t5_exec_alu_a", aa[1], 32'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_alu_a",  aa[1], 32'd0);
        check("t5_rst_valid0", {31'd0, sv0[1]}, 32'd0);
        check("t5_rst_result", res[1], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t5_no_rsp_valid0", {31'd0, sv0[1]}, 32'd0);
            check("t5_no_rsp_valid1", {31'd0, sv1[1]}, 32'd0);
            @(negedge clk);
        end

        // ALU_LAT=4: continuous requests from requester 0
        hs_n = 0; exec_n = 0;
        rv0[2] = 1'b1; rc0[2] = ALU_ADD; a0[2] = 32'd3; b0[2] = 32'd4;
        for (int c = 0; c < 14; c++) begin
            #1;
            if (rr0[2] && hs_n < 3) begin
                hs_c[hs_n] = c;
                hs_n++;
            end
            if (aa[2] == 32'd3 && c < 6) exec_n++;
            if (sv0[2]) check("t6_resp_result", res[2], 32'd7);
            @(negedge clk);
        end
        rv0[2] = 1'b0;
        check("t6_issue_count", hs_n, 32'd3);
        check("t6_exec_cycles", exec_n, 32'd4);
        if (hs_n == 3) begin
            check("t6_issue0", hs_c[0], 32'd0);
            check("t6_issue1", hs_c[1], 32'd6);
            check("t6_issue2", hs_c[2], 32'd12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
